otter_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage OTTER pipeline; sits directly upstream of the decode stage and the register file.
- Owns the PC and drives the instruction-memory port 1, which is synchronous: data returns on the cycle after the address is presented.
- Tracks the in-flight fetch, parks the returned instruction in a skid register while decode stalls, and accepts branch/jump redirects from EX.
- Presents a valid/PC/PC+4/instruction bundle to decode.

---
 rtl/otter_pkg.sv | 23 ++
 rtl/fetch_skid_buf.sv | 53 +++++
 rtl/otter_fetch_stage.sv | 97 +++++++++
 tb/tb_otter_fetch_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER pipeline definitions: word width, reset/NOP defaults,
// IF/ID bundle layout and a word-alignment helper.
package otter_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT    = 32'h0000_0013;  // addi x0,x0,0

  // IF/ID pipeline bundle
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  // Force a byte address onto a word boundary
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Skid register for the fetch stage: parks the instruction returned by
// imem on the first stalled cycle so the memory need not hold its output.
//   CLK, RST    : clock, synchronous active-high reset
//   capture_i   : latch data_i (first stalled edge with a live, unheld slot)
//   release_i   : a new fetch issues; the parked word is consumed
//   flush_i     : redirect; drop the parked word
//   data_i      : imem read data
//   held_o      : a parked word is valid
//   instr_o     : the parked word
module fetch_skid_buf
  import otter_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            capture_i,
  input  logic            release_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] data_i,
  output logic            held_o,
  output logic [XLEN-1:0] instr_o
);

  logic            held_q, held_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;

  // Release/flush take priority over capture
  always_comb begin
    held_d       = held_q;
    hold_instr_d = hold_instr_q;
    if (flush_i || release_i) begin
      held_d = 1'b0;
    end else if (capture_i) begin
      held_d       = 1'b1;
      hold_instr_d = data_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      held_q       <= 1'b0;
      hold_instr_q <= RESET_INSTR;
    end else begin
      held_q       <= held_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign held_o  = held_q;
  assign instr_o = hold_instr_q;

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER instruction-fetch stage: owns the PC, drives the synchronous imem
// port, skids the returned word across decode stalls and takes EX redirects.
//   CLK, RST        : clock, synchronous active-high reset
//   stall_i         : decode cannot accept; hold the presented bundle
//   redirect_i      : taken branch/jump from EX; kill slot and refetch
//   redirect_pc_i   : redirect target (low two bits ignored)
//   imem_addr_o     : fetch address
//   imem_rden_o     : fetch read enable
//   imem_rdata_i    : fetch data, one cycle after the request
//   if_valid_o, if_pc_o, if_npc_o, if_instr_o : bundle to decode
module otter_fetch_stage
  import otter_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  output logic            imem_rden_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_npc_o,
  output logic [XLEN-1:0] if_instr_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            slot_valid_q, slot_valid_d;
  logic [XLEN-1:0] slot_pc_q, slot_pc_d;

  logic            issue_c;
  logic            capture_c;
  logic [XLEN-1:0] fetch_addr_c;
  logic            held;
  logic [XLEN-1:0] held_instr;
  if_id_t          if_id_c;

  // Issue/target selection and next-state; redirect beats stall
  always_comb begin
    issue_c      = !RST && (redirect_i || !stall_i);
    fetch_addr_c = redirect_i ? align_word(redirect_pc_i) : pc_q;
    capture_c    = !RST && stall_i && !redirect_i && slot_valid_q && !held;
    pc_d         = pc_q;
    slot_valid_d = slot_valid_q;
    slot_pc_d    = slot_pc_q;
    if (issue_c) begin
      pc_d         = fetch_addr_c + XLEN'(4);
      slot_valid_d = 1'b1;
      slot_pc_d    = fetch_addr_c;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q         <= RESET_VECTOR;
      slot_valid_q <= 1'b0;
      slot_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      slot_valid_q <= slot_valid_d;
      slot_pc_q    <= slot_pc_d;
    end
  end

  fetch_skid_buf #(
    .RESET_INSTR (NOP_INSTR)
  ) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .capture_i (capture_c),
    .release_i (issue_c),
    .flush_i   (redirect_i),
    .data_i    (imem_rdata_i),
    .held_o    (held),
    .instr_o   (held_instr)
  );

  // Bundle to decode; a redirect kills the slot in the same cycle
  always_comb begin
    if_id_c.valid = slot_valid_q && !redirect_i && !RST;
    if_id_c.pc    = slot_pc_q;
    if_id_c.npc   = slot_pc_q + XLEN'(4);
    if_id_c.instr = !if_id_c.valid ? NOP_INSTR : (held ? held_instr : imem_rdata_i);
  end

  assign imem_addr_o = fetch_addr_c;
  assign imem_rden_o = issue_c;
  assign if_valid_o  = if_id_c.valid;
  assign if_pc_o     = if_id_c.pc;
  assign if_npc_o    = if_id_c.npc;
  assign if_instr_o  = if_id_c.instr;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Bench for otter_fetch_stage: synchronous imem model (word = 0x1000_0000 +
// word index, garbage when not read) and a slot-level reference model.
module tb_otter_fetch_stage;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] imem_addr_o;
  logic        imem_rden_o;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_npc_o;
  logic [31:0] if_instr_o;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  otter_fetch_stage #(
    .RESET_VECTOR (RV),
    .NOP_INSTR    (NOP)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rden_o   (imem_rden_o),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_npc_o      (if_npc_o),
    .if_instr_o    (if_instr_o)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Synchronous memory; output is scrambled whenever it is not read
  always @(posedge CLK) begin
    if (imem_rden_o) imem_rdata_i <= memword(imem_addr_o);
    else             imem_rdata_i <= $urandom;
  end

  // Reference model: which PC occupies the decode slot, and the next fetch
  logic [31:0] m_nf = RV;
  logic [31:0] m_pc = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_a;

  always @(posedge CLK) begin
    if (RST) begin
      m_nf = RV; m_pc = '0; m_valid = 1'b0;
    end else if (redirect_i || !stall_i) begin
      m_a     = redirect_i ? (redirect_pc_i & 32'hFFFF_FFFC) : m_nf;
      m_valid = 1'b1;
      m_pc    = m_a;
      m_nf    = m_a + 32'd4;
    end
  end

  function automatic logic e_valid();
    return m_valid && !redirect_i && !RST;
  endfunction
  function automatic logic [31:0] e_instr();
    return e_valid() ? memword(m_pc) : NOP;
  endfunction
  function automatic logic [31:0] e_addr();
    return redirect_i ? (redirect_pc_i & 32'hFFFF_FFFC) : m_nf;
  endfunction
  function automatic logic e_rden();
    return !RST && (redirect_i || !stall_i);
  endfunction

  // Apply inputs just after a rising edge, return at the falling edge
  task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] t);
    @(posedge CLK); #1;
    RST = r; stall_i = s; redirect_i = d; redirect_pc_i = t;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if ({if_valid_o, if_instr_o, imem_rden_o} !== {1'b0, NOP, 1'b0}) begin
        failures++;
        $display("FAIL reset_out cyc=%0d got v=%b i=%h rden=%b exp v=0 i=%h rden=0",
                 i, if_valid_o, if_instr_o, imem_rden_o, NOP);
      end
    end
  endtask

  task automatic test_run();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (c == 0) begin
        if ({if_valid_o, imem_rden_o, imem_addr_o} !== {1'b0, 1'b1, RV}) begin
          failures++;
          $display("FAIL run_first_fetch got v=%b rden=%b addr=%h exp v=0 rden=1 addr=%h",
                   if_valid_o, imem_rden_o, imem_addr_o, RV);
        end
      end else begin
        if ({if_valid_o, if_pc_o, if_npc_o, if_instr_o} !==
            {1'b1, RV + 32'(4*(c-1)), RV + 32'(4*c), 32'h1000_0000 + 32'(c-1)}) begin
          failures++;
          $display("FAIL run_seq cyc=%0d got v=%b pc=%h npc=%h i=%h exp pc=%h",
                   c, if_valid_o, if_pc_o, if_npc_o, if_instr_o, RV + 32'(4*(c-1)));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [97:0] snap;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      checks++;
      if ({if_valid_o, if_pc_o, if_instr_o, imem_rden_o} !== {1'b1, 32'h8, 32'h1000_0002, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold k=%0d got v=%b pc=%h i=%h rden=%b exp v=1 pc=8 i=10000002 rden=0",
                 k, if_valid_o, if_pc_o, if_instr_o, imem_rden_o);
      end
      if (k == 0) snap = {if_valid_o, if_pc_o, if_npc_o, if_instr_o, imem_rden_o};
      else begin
        checks++;
        if ({if_valid_o, if_pc_o, if_npc_o, if_instr_o, imem_rden_o} !== snap) begin
          failures++;
          $display("FAIL stall_stable k=%0d got %h exp %h", k,
                   {if_valid_o, if_pc_o, if_npc_o, if_instr_o, imem_rden_o}, snap);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid_o, if_pc_o, if_instr_o, imem_rden_o, imem_addr_o} !==
        {1'b1, 32'h8, 32'h1000_0002, 1'b1, 32'hC}) begin
      failures++;
      $display("FAIL stall_release got v=%b pc=%h i=%h rden=%b addr=%h exp pc=8 i=10000002 addr=c",
               if_valid_o, if_pc_o, if_instr_o, imem_rden_o, imem_addr_o);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid_o, if_pc_o, if_instr_o} !== {1'b1, 32'hC, 32'h1000_0003}) begin
      failures++;
      $display("FAIL stall_after got v=%b pc=%h i=%h exp v=1 pc=c i=10000003",
               if_valid_o, if_pc_o, if_instr_o);
    end
  endtask

  task automatic test_redirect();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 5; c++) drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h40);
    checks++;
    if ({if_valid_o, if_pc_o, imem_addr_o, imem_rden_o, if_instr_o} !==
        {1'b0, 32'h10, 32'h40, 1'b1, NOP}) begin
      failures++;
      $display("FAIL redir_kill got v=%b pc=%h addr=%h rden=%b i=%h exp v=0 pc=10 addr=40",
               if_valid_o, if_pc_o, imem_addr_o, imem_rden_o, if_instr_o);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if ({if_valid_o, if_pc_o, if_instr_o} !== {1'b1, 32'h40 + 32'(4*k), 32'h1000_0010 + 32'(k)}) begin
        failures++;
        $display("FAIL redir_target k=%0d got v=%b pc=%h i=%h exp pc=%h",
                 k, if_valid_o, if_pc_o, if_instr_o, 32'h40 + 32'(4*k));
      end
    end
  endtask

  task automatic test_redirect_stall();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 32'h80);
    checks++;
    if ({if_valid_o, if_instr_o, imem_addr_o, imem_rden_o} !== {1'b0, NOP, 32'h80, 1'b1}) begin
      failures++;
      $display("FAIL redir_stall_kill got v=%b i=%h addr=%h rden=%b exp v=0 i=%h addr=80 rden=1",
               if_valid_o, if_instr_o, imem_addr_o, imem_rden_o, NOP);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({if_valid_o, if_pc_o, if_instr_o, imem_rden_o} !== {1'b1, 32'h80, 32'h1000_0020, 1'b0}) begin
      failures++;
      $display("FAIL redir_stall_target got v=%b pc=%h i=%h rden=%b exp v=1 pc=80 i=10000020 rden=0",
               if_valid_o, if_pc_o, if_instr_o, imem_rden_o);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid_o, if_pc_o, if_instr_o, imem_addr_o} !== {1'b1, 32'h80, 32'h1000_0020, 32'h84}) begin
      failures++;
      $display("FAIL redir_stall_release got v=%b pc=%h i=%h addr=%h exp pc=80 addr=84",
               if_valid_o, if_pc_o, if_instr_o, imem_addr_o);
    end
  endtask

  task automatic test_align_wrap();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 2; c++) drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h43);
    checks++;
    if (imem_addr_o !== 32'h40) begin
      failures++;
      $display("FAIL align_addr got %h exp 40", imem_addr_o);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid_o, if_pc_o} !== {1'b1, 32'h40}) begin
      failures++;
      $display("FAIL align_pc got v=%b pc=%h exp v=1 pc=40", if_valid_o, if_pc_o);
    end
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid_o, if_pc_o, if_npc_o, imem_addr_o, if_instr_o} !==
        {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h4FFF_FFFF}) begin
      failures++;
      $display("FAIL wrap_top got v=%b pc=%h npc=%h addr=%h i=%h exp pc=fffffffc npc=0 addr=0",
               if_valid_o, if_pc_o, if_npc_o, imem_addr_o, if_instr_o);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid_o, if_pc_o, if_instr_o} !== {1'b1, 32'h0, 32'h1000_0000}) begin
      failures++;
      $display("FAIL wrap_zero got v=%b pc=%h i=%h exp v=1 pc=0 i=10000000",
               if_valid_o, if_pc_o, if_instr_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({if_valid_o, if_instr_o, imem_rden_o} !== {1'b0, NOP, 1'b0}) begin
      failures++;
      $display("FAIL rst_stall_out got v=%b i=%h rden=%b exp v=0 i=%h rden=0",
               if_valid_o, if_instr_o, imem_rden_o, NOP);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid_o, imem_addr_o, imem_rden_o} !== {1'b0, RV, 1'b1}) begin
      failures++;
      $display("FAIL rst_stall_fetch got v=%b addr=%h rden=%b exp v=0 addr=%h rden=1",
               if_valid_o, imem_addr_o, imem_rden_o, RV);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid_o, if_pc_o, if_instr_o} !== {1'b1, RV, memword(RV)}) begin
      failures++;
      $display("FAIL rst_stall_first got v=%b pc=%h i=%h exp v=1 pc=%h",
               if_valid_o, if_pc_o, if_instr_o, RV);
    end
  endtask

  task automatic test_random();
    logic        r, s, d;
    logic [31:0] t;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 99) < 2);
      d = ($urandom_range(0, 99) < 12);
      s = ($urandom_range(0, 99) < 35);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : 32'($urandom_range(0, 4095));
      drive(r, s, d, t);
      checks++;
      if ({if_valid_o, if_pc_o, if_npc_o, if_instr_o, imem_rden_o} !==
          {e_valid(), m_pc, m_pc + 32'd4, e_instr(), e_rden()}) begin
        failures++;
        $display("FAIL rand_bundle cyc=%0d got v=%b pc=%h npc=%h i=%h rden=%b exp v=%b pc=%h i=%h rden=%b",
                 c, if_valid_o, if_pc_o, if_npc_o, if_instr_o, imem_rden_o,
                 e_valid(), m_pc, e_instr(), e_rden());
      end
      if (e_rden()) begin
        checks++;
        if (imem_addr_o !== e_addr()) begin
          failures++;
          $display("FAIL rand_addr cyc=%0d got %h exp %h", c, imem_addr_o, e_addr());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_align_wrap();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
